matrix_operand_loader: RTL



---
 rtl/matrix_operand_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/matrix_operand_loader.sv
// Serial element stream to packed A/B operand buses with start/done launch control.
// Define LOADER_TRANSPOSE_B_EN to accept the B stream in column-major order.
module matrix_operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int P          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [M*N*DATA_WIDTH-1:0]    matrix_a,
    output logic [N*P*DATA_WIDTH-1:0]    matrix_b,
    output logic                         start,
    input  logic                         done,
    output logic                         busy,
    output logic                         load_err
);

    localparam int NA = M * N;
    localparam int NB = N * P;
    localparam int AW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] LOAD_A    = 2'd0;
    localparam logic [1:0] LOAD_B    = 2'd1;
    localparam logic [1:0] START     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]                  r_state;
    logic [AW-1:0]               r_a_cnt;
    logic [BW-1:0]               r_b_cnt;
    logic [M*N*DATA_WIDTH-1:0]   r_matrix_a;
    logic [N*P*DATA_WIDTH-1:0]   r_matrix_b;
    logic                        r_start;
    logic                        r_load_err;
    logic                        r_done_q;

    logic                        w_fire;
    logic                        w_b_fire;
    logic                        w_a_end;
    logic                        w_b_end;
    logic                        w_b_clr;
    logic [BW-1:0]               w_slot_b;

    assign s_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign busy     = (r_state == START) || (r_state == WAIT_DONE);
    assign start    = r_start;
    assign load_err = r_load_err;
    assign matrix_a = r_matrix_a;
    assign matrix_b = r_matrix_b;

    assign w_fire   = s_valid && s_ready;
    assign w_b_fire = w_fire && (r_state == LOAD_B);
    assign w_a_end  = (r_a_cnt == AW'(NA - 1));
    assign w_b_end  = (r_b_cnt == BW'(NB - 1));
    assign w_b_clr  = w_b_fire && (w_b_end || s_last);

`ifdef LOADER_TRANSPOSE_B_EN
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    logic [RW-1:0] r_b_row;
    logic [CW-1:0] r_b_col;

    // Column-major stream: row index runs fastest, column steps on row wrap.
    assign w_slot_b = BW'(r_b_row * P + r_b_col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b_row <= '0;
            r_b_col <= '0;
        end else if (w_b_clr) begin
            r_b_row <= '0;
            r_b_col <= '0;
        end else if (w_b_fire) begin
            if (r_b_row == RW'(N - 1)) begin
                r_b_row <= '0;
                r_b_col <= r_b_col + 1'b1;
            end else begin
                r_b_row <= r_b_row + 1'b1;
            end
        end
    end
`else
    assign w_slot_b = r_b_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOAD_A;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_matrix_a <= '0;
            r_matrix_b <= '0;
            r_start    <= 1'b0;
            r_load_err <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= done;
            r_start  <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (w_fire) begin
                        r_matrix_a[r_a_cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        if (s_last) begin
                            r_load_err <= 1'b1;
                            r_a_cnt    <= '0;
                        end else if (w_a_end) begin
                            r_a_cnt <= '0;
                            r_state <= LOAD_B;
                        end else begin
                            r_a_cnt <= r_a_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_fire) begin
                        r_matrix_b[w_slot_b*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        if (w_b_end) begin
                            // Missing s_last is flagged but the set still launches.
                            r_b_cnt <= '0;
                            r_start <= 1'b1;
                            r_state <= START;
                            if (!s_last) r_load_err <= 1'b1;
                        end else if (s_last) begin
                            r_load_err <= 1'b1;
                            r_b_cnt    <= '0;
                            r_state    <= LOAD_A;
                        end else begin
                            r_b_cnt <= r_b_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done && !r_done_q) r_state <= LOAD_A;
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
